// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch stage. Holds the architectural fetch PC, exposes it to the
// external sequential next-PC adder and loads the adder result back verbatim.
// Reads go to a 1-cycle-latency instruction memory; the returned word is paired
// with its PC and offered to decode over a valid/ready handshake. A one-entry
// skid buffer catches the returning word when decode stalls, and a redirect
// (branch/jump) flushes everything in flight.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   pc_out            current fetch PC, drives the next-PC adder
//   npc_in            adder result, sequential next PC
//   redirect_valid    one-cycle redirect pulse
//   redirect_addr     redirect target (low two bits are forced to zero)
//   imem_en/addr      instruction memory read request
//   imem_rdata        read data, valid the cycle after imem_en
//   if_valid/ready    handshake to decode
//   if_pc/if_instr    delivered PC and instruction word
//   misalign_err      one-cycle pulse after a redirect with addr[1:0] != 0
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BOOT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out,
    input  logic [31:0] npc_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [31:0] pc_q;
    logic [3:0]  boot_cnt;
    logic        inflight_q;
    logic [31:0] inflight_pc_q;
    logic        skid_valid_q;
    logic [31:0] skid_pc_q;
    logic [31:0] skid_instr_q;

    logic        issue;
    logic        skid_capture;
    logic        skid_release;

    // State register for the boot/run/hold sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake control. A new read is only issued when the
    // word already in flight (if any) is being consumed this cycle, so the
    // skid buffer and the in-flight slot are never both occupied at issue.
    // The skid catches the memory return when decode refuses it; that word
    // only exists for one cycle on imem_rdata.
    always_comb begin
        issue        = (state_q == RUN) && !redirect_valid && !skid_valid_q &&
                       (!inflight_q || if_ready);
        skid_capture = inflight_q && !skid_valid_q && !if_ready && !redirect_valid;
        skid_release = (state_q == HOLD) && skid_valid_q && if_ready && !redirect_valid;

        state_d = state_q;
        if (redirect_valid) begin
            state_d = RUN;
        end else begin
            case (state_q)
                BOOT: begin
                    if (boot_cnt == BOOT_LAST) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (skid_capture) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (skid_release) begin
                        state_d = RUN;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end

    // Datapath registers. Redirect discards both the in-flight return and the
    // skid entry; the PC is taken from the adder unmodified so wrap-around
    // stays the adder's responsibility.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            boot_cnt      <= 4'd0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'd0;
            skid_valid_q  <= 1'b0;
            skid_pc_q     <= 32'd0;
            skid_instr_q  <= 32'd0;
            misalign_err  <= 1'b0;
        end else if (redirect_valid) begin
            pc_q         <= {redirect_addr[31:2], 2'b00};
            inflight_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            misalign_err <= |redirect_addr[1:0];
        end else begin
            misalign_err <= 1'b0;
            if (state_q == BOOT) begin
                boot_cnt <= boot_cnt + 4'd1;
            end
            inflight_q <= issue;
            if (issue) begin
                pc_q          <= npc_in;
                inflight_pc_q <= pc_q;
            end
            if (skid_capture) begin
                skid_valid_q <= 1'b1;
                skid_pc_q    <= inflight_pc_q;
                skid_instr_q <= imem_rdata;
            end else if (skid_release) begin
                skid_valid_q <= 1'b0;
            end
        end
    end

    // The skid entry is always older than anything in flight, so it wins the
    // output mux to keep program order.
    always_comb begin
        pc_out    = pc_q;
        imem_en   = issue;
        imem_addr = pc_q;
        if_valid  = !redirect_valid && (skid_valid_q || inflight_q);
        if (skid_valid_q) begin
            if_pc    = skid_pc_q;
            if_instr = skid_instr_q;
        end else begin
            if_pc    = inflight_pc_q;
            if_instr = imem_rdata;
        end
    end

endmodule
